// File: rtl/fork_eager.sv
// Eager fork: broadcasts each input token to OUTPUTS consumers, letting each
// branch take the token as soon as it is ready. The input is consumed only
// once every branch has taken it; per-branch done bits block redelivery.
module fork_eager #(
  parameter int unsigned OUTPUTS   = 2,
  parameter int unsigned DATA_TYPE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_TYPE-1:0]           ins,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  output logic [OUTPUTS*DATA_TYPE-1:0]   outs,
  output logic [OUTPUTS-1:0]             outs_valid,
  input  logic [OUTPUTS-1:0]             outs_ready
);

  logic [OUTPUTS-1:0] done_q;
  logic [OUTPUTS-1:0] done_d;
  logic [OUTPUTS-1:0] satisfied;
  logic [OUTPUTS-1:0] branch_xfer;
  logic               in_xfer;

  // Replicate input data onto every branch slice; no data storage.
  always_comb begin
    outs = '0;
    for (int unsigned i = 0; i < OUTPUTS; i++) begin
      outs[i*DATA_TYPE +: DATA_TYPE] = ins;
    end
  end

  // Handshake: valid/ready are forced low while reset is asserted.
  always_comb begin
    satisfied   = done_q | outs_ready;
    outs_valid  = (rst && ins_valid) ? ~done_q : '0;
    ins_ready   = rst && (&satisfied);
    branch_xfer = outs_valid & outs_ready;
    in_xfer     = ins_valid && ins_ready;
  end

  // Next done: a completed input transfer clears all bits, even a branch that
  // transferred in the same cycle, so the next token starts fresh.
  always_comb begin
    done_d = done_q;
    if (in_xfer) begin
      done_d = '0;
    end else begin
      done_d = done_q | branch_xfer;
    end
  end

  // Delivered-bit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_fork_eager.sv
// Self-checking bench for fork_eager with OUTPUTS=3, DATA_TYPE=32. Expected
// tokens are queued per branch when offered and popped on branch transfers.
module tb_fork_eager;

  localparam int unsigned N = 3;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic [W-1:0]   ins;
  logic           ins_valid;
  logic           ins_ready;
  logic [N*W-1:0] outs;
  logic [N-1:0]   outs_valid;
  logic [N-1:0]   outs_ready;

  int total;
  int bad;
  int in_xfers;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  fork_eager #(.OUTPUTS(N), .DATA_TYPE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue a token as expected on every branch and present it on the input.
  task automatic offer(input logic [W-1:0] tok);
    q0.push_back(tok);
    q1.push_back(tok);
    q2.push_back(tok);
    ins       = tok;
    ins_valid = 1'b1;
  endtask

  task automatic pop_check(input int b, input logic [W-1:0] data);
    logic [W-1:0] e;
    int sz;
    sz = (b == 0) ? q0.size() : (b == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      check($sformatf("dup_b%0d", b), 32'd1, 32'd0);
    end else begin
      case (b)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("data_b%0d", b), data, e);
    end
  endtask

  // Scoreboard monitor: every branch transfer must match the next expected token.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (outs_valid[i] && outs_ready[i]) pop_check(i, outs[i*W +: W]);
      end
      if (ins_valid && ins_ready) in_xfers++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int xf0;
    total = 0; bad = 0; in_xfers = 0;
    rst = 1'b0; ins = 32'h1234; ins_valid = 1'b1; outs_ready = 3'b111;

    // Reset: handshake forced low, data still mirrors input.
    @(negedge clk);
    check("rst_valid", 32'(outs_valid), 32'd0);
    check("rst_ready", 32'(ins_ready), 32'd0);
    check("rst_outs2", outs[2*W +: W], 32'h1234);
    next_cycle();
    ins_valid = 1'b0; outs_ready = 3'b000;
    next_cycle();
    rst = 1'b1;

    // 1: all branches ready.
    offer(32'hA5); outs_ready = 3'b111;
    @(negedge clk);
    check("t1_valid", 32'(outs_valid), 32'h7);
    check("t1_ready", 32'(ins_ready), 32'd1);
    next_cycle();
    ins_valid = 1'b0;

    // 2: partial stall.
    next_cycle();
    offer(32'hA5); outs_ready = 3'b101;
    @(negedge clk);
    check("t2_c0_ready", 32'(ins_ready), 32'd0);
    check("t2_c0_valid", 32'(outs_valid), 32'h7);
    next_cycle();
    outs_ready = 3'b010;
    @(negedge clk);
    check("t2_c1_valid", 32'(outs_valid), 32'h2);
    check("t2_c1_ready", 32'(ins_ready), 32'd1);
    next_cycle();
    offer(32'h77); outs_ready = 3'b000;
    @(negedge clk);
    check("t2_c2_valid", 32'(outs_valid), 32'h7);
    check("t2_c2_ready", 32'(ins_ready), 32'd0);
    next_cycle();
    outs_ready = 3'b111;
    next_cycle();

    // 3: staggered ready, one branch per cycle.
    for (int t = 1; t <= 3; t++) begin
      offer(W'(t));
      for (int c = 0; c < 3; c++) begin
        outs_ready = 3'(1 << c);
        @(negedge clk);
        check($sformatf("t3_tok%0d_c%0d_valid", t, c), 32'(outs_valid), 32'(3'b111 & ~3'((1 << c) - 1)));
        check($sformatf("t3_tok%0d_c%0d_ready", t, c), 32'(ins_ready), (c == 2) ? 32'd1 : 32'd0);
        next_cycle();
      end
    end

    // 4: reset mid-token; consumers reset too, so the token is re-expected everywhere.
    offer(32'h55); outs_ready = 3'b001;
    @(negedge clk);
    check("t4_pre_valid", 32'(outs_valid), 32'h7);
    check("t4_pre_ready", 32'(ins_ready), 32'd0);
    next_cycle();
    rst = 1'b0; outs_ready = 3'b000;
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    check("t4_rst_valid", 32'(outs_valid), 32'd0);
    check("t4_rst_ready", 32'(ins_ready), 32'd0);
    next_cycle();
    rst = 1'b1;
    offer(32'h55); outs_ready = 3'b000;
    @(negedge clk);
    check("t4_post_valid", 32'(outs_valid), 32'h7);
    next_cycle();
    outs_ready = 3'b111;
    @(negedge clk);
    check("t4_drain_ready", 32'(ins_ready), 32'd1);
    next_cycle();

    // 5: back-to-back tokens, all ready.
    xf0 = in_xfers;
    for (int k = 0; k < 3; k++) begin
      offer(32'h10 + W'(k)); outs_ready = 3'b111;
      @(negedge clk);
      check($sformatf("t5_k%0d_valid", k), 32'(outs_valid), 32'h7);
      check($sformatf("t5_k%0d_ready", k), 32'(ins_ready), 32'd1);
      next_cycle();
    end
    check("t5_xfers", 32'(in_xfers - xf0), 32'd3);

    // 6: idle; ready without valid must not disturb done.
    ins_valid = 1'b0; outs_ready = 3'b011;
    @(negedge clk);
    check("t6_a_valid", 32'(outs_valid), 32'd0);
    check("t6_a_ready", 32'(ins_ready), 32'd0);
    next_cycle();
    outs_ready = 3'b111;
    @(negedge clk);
    check("t6_b_valid", 32'(outs_valid), 32'd0);
    check("t6_b_ready", 32'(ins_ready), 32'd1);
    next_cycle();
    offer(32'h99); outs_ready = 3'b000;
    @(negedge clk);
    check("t6_c_valid", 32'(outs_valid), 32'h7);
    next_cycle();
    outs_ready = 3'b111;
    next_cycle();
    ins_valid = 1'b0;
    next_cycle();

    // Every offered token delivered exactly once to each branch.
    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
    check("q2_left", 32'(q2.size()), 32'd0);
    check("in_xfers", 32'(in_xfers), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fork_eager.md
# fork_eager

Eager fork for the dataflow handshake fabric, the dual of the merge. It takes one valid/ready data stream and broadcasts each token to `OUTPUTS` consumers. Each consumer receives the token as soon as it is ready, independently of the others. The input token is consumed only once every output has taken it. Per-output "already delivered" registers keep a token from being delivered twice to a fast consumer while a slow consumer stalls.

## Interface

Parameters:
- `OUTPUTS`, default 2: number of consumer branches; must be ≥ 1.
- `DATA_TYPE`, default 32: token data width in bits; must be ≥ 1.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: one clock; reset is synchronous and active-low (asserted when 0, sampled on the rising edge of `clk`).
- `ins`, input, `DATA_TYPE`: input token data.
- `ins_valid`, input, 1: input token present.
- `ins_ready`, output, 1: input token consumed this cycle when high together with `ins_valid`.
- `outs`, output, `OUTPUTS*DATA_TYPE`: replicated data; slice `i` is `outs[i*DATA_TYPE +: DATA_TYPE]`.
- `outs_valid`, output, `OUTPUTS`: per-branch valid.
- `outs_ready`, input, `OUTPUTS`: per-branch ready.

## Operation

- State: `done[OUTPUTS-1:0]`. Bit `i` = 1 means the current input token has already been delivered to branch `i`.
- Data: every `outs` slice equals `ins` combinationally. There is no data register.
- `outs_valid[i] = ins_valid & ~done[i]`.
- Branch `i` is satisfied when `done[i] | outs_ready[i]`.
- `ins_ready` = AND of satisfied over all branches.
- Branch transfer `i` = `outs_valid[i] & outs_ready[i]`. Input transfer = `ins_valid & ins_ready`.
- Next-state rule for each bit `i`, highest priority first:
  - `rst` = 0: `done[i]` ← 0.
  - Input transfer: `done[i]` ← 0. The token is complete, so the next token starts fresh even if branch `i` also transferred this cycle.
  - Branch transfer on `i`: `done[i]` ← 1.
  - Otherwise: hold.
- While `rst` = 0, `outs_valid` is forced to all-zero and `ins_ready` is forced to 0. `outs` still mirrors `ins`.
- `OUTPUTS` = 1 degenerates to a wire: `done` never sets, because any branch transfer is also an input transfer.
- No token is duplicated or dropped. Each branch sees exactly one transfer per input token.
- Reset mid-token: all `done` bits clear. Upstream keeps `ins_valid` high per protocol, so the held token is re-offered to every branch after reset. Consumers are reset in the same domain, so no duplicate is observed.
- `ins_valid` = 0: all `outs_valid` are 0, `done` holds at 0, and `ins_ready` = AND of `outs_ready`. Asserting ready without valid is legal.

## Timing

- Latency 0: data and valid pass combinationally from input to outputs in the same cycle.
- Combinational paths:
  - `ins_valid` → `outs_valid`.
  - `outs_ready` → `ins_ready`.
  - `ins` → `outs`.
- Throughput: one token per cycle when all branches are ready.
- Register reset values: `done` = 0. Output values during reset are as stated in Operation (`outs_valid` = 0, `ins_ready` = 0).
- `done` bits change only on the clock edge. A branch that transferred in cycle t sees `outs_valid[i]` = 0 from cycle t+1 until the input transfer.
- Simultaneous case: if the last outstanding branch transfers in the same cycle as the input transfer, `done` clears. The next token, if valid, appears on all branches at t+1.

## Test plan

1. All branches ready. `OUTPUTS`=3, `ins`=0x000000A5, `ins_valid`=1, `outs_ready`=3'b111 → in the same cycle `outs_valid`=3'b111, `ins_ready`=1, and all slices read 0xA5. `done` stays 3'b000.
2. Partial stall. Cycle 0: `outs_ready`=3'b101 → `ins_ready`=0, `outs_valid`=3'b111. Cycle 1: `outs_valid`=3'b010; `outs_ready`=3'b010 → `ins_ready`=1. Cycle 2: `done`=000. Each branch logs exactly one 0xA5.
3. Staggered ready, one branch per cycle (`outs_ready` 001, 010, 100) → `outs_valid` is 111, 110, 100. `ins_ready`=1 only in cycle 2. Three tokens 0x1, 0x2, 0x3 are streamed this way with no duplicates.
4. Reset mid-token. Branch 0 takes 0x55; `rst`=0 for one cycle → during reset `outs_valid`=000 and `ins_ready`=0. After release, with `ins_valid` still 1, `outs_valid`=3'b111.
5. Back-to-back. Tokens 0x10, 0x11, 0x12 arrive with all ready → three consecutive input transfers, and each branch receives 0x10, 0x11, 0x12 in order.
6. Idle. `ins_valid`=0, `outs_ready`=3'b011 → `outs_valid`=000, `ins_ready`=0. Then `outs_ready`=111 → `ins_ready`=1, and `done` does not change.
